// File: rtl/prog_ctr.sv
// Program counter sequencer: IDLE/RUN/DONE control with absolute and relative
// jumps, stall, halt, and a saturating count of PC-advancing cycles.
module prog_ctr #(
  parameter int D = 12
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [D-1:0] StartAddr,
  input  logic         Stall,
  input  logic         AbsJump,
  input  logic [D-1:0] Target,
  input  logic         RelJump,
  input  logic [D-1:0] Offset,
  input  logic         Halt,
  output logic [D-1:0] ProgCtr,
  output logic         Running,
  output logic         Done,
  output logic [15:0]  InstCnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= '0;
      InstCnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state   <= RUN;
            ProgCtr <= StartAddr;
            InstCnt <= '0;
          end
        end
        RUN: begin
          if (Halt) begin
            state <= DONE;
          end else if (!Stall) begin
            // Offset is two's complement; modular addition handles the sign.
            if (AbsJump)
              ProgCtr <= Target;
            else if (RelJump)
              ProgCtr <= ProgCtr + Offset;
            else
              ProgCtr <= ProgCtr + 1'b1;
            if (InstCnt != '1)
              InstCnt <= InstCnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == DONE);

endmodule

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr: stimulus pushes expected post-edge state,
// a monitor pops and compares shortly after every rising edge.
module tb_prog_ctr;

  localparam int D = 12;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [D-1:0] StartAddr = '0;
  logic         Stall = 1'b0;
  logic         AbsJump = 1'b0;
  logic [D-1:0] Target = '0;
  logic         RelJump = 1'b0;
  logic [D-1:0] Offset = '0;
  logic         Halt = 1'b0;
  logic [D-1:0] ProgCtr;
  logic         Running;
  logic         Done;
  logic [15:0]  InstCnt;

  prog_ctr #(.D(D)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .AbsJump(AbsJump), .Target(Target), .RelJump(RelJump),
    .Offset(Offset), .Halt(Halt), .ProgCtr(ProgCtr), .Running(Running),
    .Done(Done), .InstCnt(InstCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [D-1:0] pc;
    logic         run;
    logic         done;
    logic [15:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Drive one cycle of inputs and record the state expected after the edge.
  task automatic cyc(input logic rst, input logic st, input logic [D-1:0] sa,
                     input logic stl, input logic aj, input logic [D-1:0] tg,
                     input logic rj, input logic [D-1:0] off, input logic hlt,
                     input logic [D-1:0] epc, input logic erun, input logic edone,
                     input logic [15:0] ecnt);
    exp_t e;
    @(negedge Clk);
    Reset = rst; Start = st; StartAddr = sa; Stall = stl; AbsJump = aj;
    Target = tg; RelJump = rj; Offset = off; Halt = hlt;
    e.pc = epc; e.run = erun; e.done = edone; e.cnt = ecnt;
    exp_q.push_back(e);
    @(posedge Clk);
  endtask

  // Plain run cycle with no controls asserted.
  task automatic idle(input logic [D-1:0] epc, input logic erun,
                      input logic edone, input logic [15:0] ecnt);
    cyc(0, 0, '0, 0, 0, '0, 0, '0, 0, epc, erun, edone, ecnt);
  endtask

  always @(posedge Clk) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      step_no++;
      checks++;
      if (ProgCtr !== e.pc || Running !== e.run || Done !== e.done || InstCnt !== e.cnt) begin
        errors++;
        $display("FAIL step%0d: got pc=%0d run=%b done=%b cnt=%0d, expected pc=%0d run=%b done=%b cnt=%0d",
                 step_no, ProgCtr, Running, Done, InstCnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  end

  initial begin
    int unsigned wait_cyc;
    logic [15:0] ec;
    logic [D-1:0] ep;

    // reset state
    cyc(1, 0, '0, 0, 0, '0, 0, '0, 0, 0, 0, 0, 0);
    // start at 2, three increments
    cyc(0, 1, 12'd2, 0, 0, '0, 0, '0, 0, 2, 1, 0, 0);
    idle(3, 1, 0, 1);
    idle(4, 1, 0, 2);
    idle(5, 1, 0, 3);
    // Start while running is ignored
    cyc(0, 1, 12'd100, 0, 0, '0, 0, '0, 0, 6, 1, 0, 4);
    cyc(0, 0, '0, 0, 1, 12'd4, 0, '0, 0, 4, 1, 0, 5);
    // AbsJump beats RelJump
    cyc(0, 0, '0, 0, 1, 12'd159, 1, 12'd20, 0, 159, 1, 0, 6);
    cyc(0, 0, '0, 0, 1, 12'd4, 0, '0, 0, 4, 1, 0, 7);
    // negative and positive relative jumps
    cyc(0, 0, '0, 0, 0, '0, 1, 12'hFFB, 0, 4095, 1, 0, 8);
    cyc(0, 0, '0, 0, 0, '0, 1, 12'd20, 0, 19, 1, 0, 9);
    // increment wraps 4095 -> 0
    cyc(0, 0, '0, 0, 1, 12'd4095, 0, '0, 0, 4095, 1, 0, 10);
    idle(0, 1, 0, 11);
    // stall with AbsJump held; jump lands when stall drops
    cyc(0, 0, '0, 1, 1, 12'd191, 0, '0, 0, 0, 1, 0, 11);
    cyc(0, 0, '0, 1, 1, 12'd191, 0, '0, 0, 0, 1, 0, 11);
    cyc(0, 0, '0, 0, 1, 12'd191, 0, '0, 0, 191, 1, 0, 12);
    // Halt beats Stall, then DONE holds against stray controls
    cyc(0, 0, '0, 1, 0, '0, 0, '0, 1, 191, 0, 1, 12);
    for (int i = 0; i < 10; i++)
      cyc(0, 0, '0, i[0], i[1], 12'd55, i[2], 12'd7, 1, 191, 0, 1, 12);
    cyc(0, 1, 12'd2, 0, 0, '0, 0, '0, 0, 2, 1, 0, 0);
    // reset mid-jump in RUN goes to IDLE, not DONE
    cyc(0, 0, '0, 0, 1, 12'd177, 0, '0, 0, 177, 1, 0, 1);
    cyc(1, 0, '0, 0, 0, '0, 1, 12'd5, 0, 0, 0, 0, 0);
    // controls ignored in IDLE
    cyc(0, 0, '0, 0, 1, 12'd9, 1, 12'd3, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, '0, 0, '0, 1, 0, 0, 0, 0);
    cyc(0, 1, 12'd4094, 0, 0, '0, 0, '0, 0, 4094, 1, 0, 0);
    idle(4095, 1, 0, 1);
    // reset mid-stall
    cyc(1, 0, '0, 1, 1, 12'd8, 0, '0, 0, 0, 0, 0, 0);
    // InstCnt saturation at 16'hFFFF
    cyc(0, 1, 12'd0, 0, 0, '0, 0, '0, 0, 0, 1, 0, 0);
    ec = 16'd0;
    ep = '0;
    for (int i = 0; i < 65540; i++) begin
      ep = ep + 1'b1;
      if (ec != 16'hFFFF) ec = ec + 16'd1;
      idle(ep, 1, 0, ec);
    end
    cyc(0, 0, '0, 0, 0, '0, 0, '0, 1, ep, 0, 1, 16'hFFFF);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge Clk);
      wait_cyc++;
    end
    #5;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_ctr.md
PROG_CTR -- requirements
Module: prog_ctr

Interface
REQ-001 SHALL have parameter D, default 12, giving the program-counter and jump-target width in bits.
REQ-002 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-004 SHALL have port Start  input  1  begin or restart execution from StartAddr.
REQ-005 SHALL have port StartAddr  input  D  first instruction address loaded on Start.
REQ-006 SHALL have port Stall  input  1  hold ProgCtr for this cycle.
REQ-007 SHALL have port AbsJump  input  1  load ProgCtr from Target (branch-target LUT output).
REQ-008 SHALL have port Target  input  D  absolute jump address from the branch-target LUT.
REQ-009 SHALL have port RelJump  input  1  add Offset to ProgCtr.
REQ-010 SHALL have port Offset  input  D  two's-complement relative jump distance.
REQ-011 SHALL have port Halt  input  1  end of program from decode.
REQ-012 SHALL have port ProgCtr  output  D  current instruction address (registered).
REQ-013 SHALL have port Running  output  1  high while in state RUN.
REQ-014 SHALL have port Done  output  1  high while in state DONE.
REQ-015 SHALL have port InstCnt  output  16  count of PC-advancing cycles since the last Start.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, DONE; Running and Done decoded from state only (Moore).
REQ-017 IDLE: ProgCtr held; Start -> ProgCtr<=StartAddr, InstCnt<=0, next RUN; otherwise remain IDLE.
REQ-018 RUN: exactly one action per cycle, priority Halt > Stall > AbsJump > RelJump > increment.
REQ-019 RUN + Halt: ProgCtr held, next DONE, InstCnt unchanged.
REQ-020 RUN + Stall (no Halt): ProgCtr and InstCnt held, remain RUN.
REQ-021 RUN + AbsJump: ProgCtr<=Target next cycle; AbsJump wins over simultaneous RelJump.
REQ-022 RUN + RelJump: ProgCtr<=(ProgCtr+Offset) mod 2^D; Offset sign-interpreted, so all-ones means -1.
REQ-023 RUN, no control asserted: ProgCtr<=(ProgCtr+1) mod 2^D; 2^D-1 wraps to 0.
REQ-024 Every RUN cycle taking AbsJump, RelJump or increment SHALL increment InstCnt by 1, saturating at 16'hFFFF.
REQ-025 Start while in RUN SHALL be ignored.
REQ-026 DONE: ProgCtr and InstCnt held; Start -> same action as REQ-017, next RUN.
REQ-027 Latency: control inputs sampled at edge N affect ProgCtr visible after edge N; ProgCtr has no combinational path from inputs.
REQ-028 Stall, AbsJump, RelJump and Halt SHALL be ignored outside RUN.

Reset
REQ-029 Reset high at a rising edge SHALL force state IDLE, ProgCtr=0, InstCnt=0, Running=0, Done=0.
REQ-030 Reset SHALL take priority over every other input in every state, including mid-jump and mid-stall.
REQ-031 Reset asserted during RUN SHALL return to IDLE without entering DONE.

Verification
REQ-032 Reset, Start with StartAddr=2, then 3 idle cycles -> ProgCtr 2,3,4,5; Running=1; InstCnt=3.
REQ-033 In RUN at ProgCtr=4, AbsJump=1 and RelJump=1 with Target=159, Offset=20 -> ProgCtr=159 next cycle (AbsJump priority).
REQ-034 At ProgCtr=4, RelJump Offset=12'hFFB -> ProgCtr=4095 (4-5 mod 4096); then RelJump Offset=20 -> ProgCtr=19; then increment from ProgCtr=4095 -> 0.
REQ-035 Stall for 2 cycles with AbsJump held high -> ProgCtr and InstCnt unchanged; jump to Target takes effect the cycle Stall drops.
REQ-036 At ProgCtr=191, Halt together with Stall -> DONE, Done=1, ProgCtr=191 held for 10 cycles; Start with StartAddr=2 -> ProgCtr=2, InstCnt=0, Running=1.
REQ-037 Reset asserted in RUN at ProgCtr=177 with RelJump=1 -> next cycle IDLE, ProgCtr=0, InstCnt=0, Running=0, Done=0.
